// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounces mode/inc buttons and runs RUN / SET_HRS / SET_MIN.
// While setting, it holds the timekeeper, edits a shadow HH:MM, blinks the edited digits and loads the result back.
module clock_set_ctrl #(
  parameter logic [25:0] DEBOUNCE_CYC = 26'd269999,
  parameter logic [25:0] REPEAT_DELAY = 26'd13499999,
  parameter logic [25:0] REPEAT_RATE  = 26'd2699999,
  parameter logic [25:0] BLINK_HALF   = 26'd6749999,
  parameter logic [29:0] TIMEOUT_CYC  = 30'd809999999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [3:0] cur_hrs_1,
  input  logic [3:0] cur_hrs_0,
  input  logic [3:0] cur_min_1,
  input  logic [3:0] cur_min_0,
  output logic       run_en,
  output logic       load,
  output logic [3:0] load_hrs_1,
  output logic [3:0] load_hrs_0,
  output logic [3:0] load_min_1,
  output logic [3:0] load_min_0,
  output logic [3:0] disp_hrs_1,
  output logic [3:0] disp_hrs_0,
  output logic [3:0] disp_min_1,
  output logic [3:0] disp_min_0,
  output logic [3:0] digit_blank,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HRS = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  // Index 0 = mode button, index 1 = inc button.
  logic [1:0] btn_raw;
  logic [1:0] press_vec;
  logic       inc_stable;

  assign btn_raw = {btn_inc_n, btn_mode_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic        sync0_reg;
      logic        sync1_reg;
      logic        stable_reg;
      logic        stable_d_reg;
      logic        press_reg;
      logic [25:0] db_cnt_reg;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sync0_reg    <= 1'b1;
          sync1_reg    <= 1'b1;
          stable_reg   <= 1'b1;
          stable_d_reg <= 1'b1;
          press_reg    <= 1'b0;
          db_cnt_reg   <= '0;
        end else begin
          sync0_reg    <= btn_raw[gi];
          sync1_reg    <= sync0_reg;
          stable_d_reg <= stable_reg;
          press_reg    <= stable_d_reg & ~stable_reg;
          if (sync1_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DEBOUNCE_CYC - 26'd1) begin
            stable_reg <= sync1_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 26'd1;
          end
        end
      end

      assign press_vec[gi] = press_reg;
    end
  endgenerate

  assign inc_stable = g_btn[1].stable_reg;

  // Hold counter: after the first repeat it is rewound so the next repeat lands REPEAT_RATE later.
  logic [25:0] hold_cnt_reg;
  logic        rep_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_cnt_reg <= '0;
      rep_reg      <= 1'b0;
    end else begin
      rep_reg <= 1'b0;
      if (inc_stable) begin
        hold_cnt_reg <= '0;
      end else if (hold_cnt_reg == REPEAT_DELAY) begin
        hold_cnt_reg <= REPEAT_DELAY - REPEAT_RATE + 26'd1;
        rep_reg      <= 1'b1;
      end else begin
        hold_cnt_reg <= hold_cnt_reg + 26'd1;
      end
    end
  end

  logic mode_ev;
  logic inc_ev;
  assign mode_ev = press_vec[0];
  assign inc_ev  = press_vec[1] | rep_reg;

  function automatic logic [7:0] inc_hrs(input logic [7:0] h);
    if (h == 8'h23)          return 8'h00;
    else if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    else                     return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[7:4] == 4'd5) return 8'h00;
      else                return {m[7:4] + 4'd1, 4'd0};
    end else begin
      return {m[7:4], m[3:0] + 4'd1};
    end
  endfunction

  logic [15:0] cur_vec;
  logic        capture_bad;
  assign cur_vec     = {cur_hrs_1, cur_hrs_0, cur_min_1, cur_min_0};
  assign capture_bad = (cur_hrs_1 > 4'd2) || (cur_hrs_0 > 4'd9) || (cur_min_1 > 4'd9) ||
                       (cur_min_0 > 4'd9) || ((cur_hrs_1 == 4'd2) && (cur_hrs_0 > 4'd3));

  state_t      state_reg, state_next;
  logic [15:0] sh_reg, sh_next;
  logic [25:0] blink_cnt_reg, blink_cnt_next;
  logic        phase_reg, phase_next;
  logic [29:0] to_cnt_reg, to_cnt_next;
  logic        run_en_reg, run_en_next;
  logic        load_reg, load_next;
  logic [15:0] load_val_reg, load_val_next;
  logic [15:0] disp_reg, disp_next;
  logic [3:0]  blank_reg, blank_next;

  always_comb begin
    state_next     = state_reg;
    sh_next        = sh_reg;
    load_next      = 1'b0;
    blink_cnt_next = blink_cnt_reg + 26'd1;
    phase_next     = phase_reg;
    to_cnt_next    = to_cnt_reg + 30'd1;
    if (blink_cnt_reg == BLINK_HALF - 26'd1) begin
      blink_cnt_next = '0;
      phase_next     = ~phase_reg;
    end
    if (mode_ev || inc_ev) begin
      to_cnt_next = '0;
    end

    case (state_reg)
      ST_SET_HRS, ST_SET_MIN: begin
        if (mode_ev) begin
          // Mode wins over a coincident increment.
          state_next     = (state_reg == ST_SET_HRS) ? ST_SET_MIN : ST_RUN;
          load_next      = (state_reg == ST_SET_MIN);
          blink_cnt_next = '0;
          phase_next     = 1'b0;
        end else if (inc_ev) begin
          if (state_reg == ST_SET_HRS) sh_next[15:8] = inc_hrs(sh_reg[15:8]);
          else                         sh_next[7:0]  = inc_min(sh_reg[7:0]);
          blink_cnt_next = '0;
          phase_next     = 1'b0;
        end else if (to_cnt_reg == TIMEOUT_CYC - 30'd1) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        blink_cnt_next = '0;
        phase_next     = 1'b0;
        to_cnt_next    = '0;
        if (mode_ev) begin
          state_next = ST_SET_HRS;
          sh_next    = capture_bad ? 16'h0000 : cur_vec;
        end
      end
    endcase

    run_en_next   = (state_next == ST_RUN);
    disp_next     = (state_next == ST_RUN) ? cur_vec : sh_next;
    load_val_next = load_next ? sh_reg : load_val_reg;
    case (state_next)
      ST_SET_HRS: blank_next = {phase_next, phase_next, 2'b00};
      ST_SET_MIN: blank_next = {2'b00, phase_next, phase_next};
      default:    blank_next = 4'b0000;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= ST_RUN;
      sh_reg        <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      to_cnt_reg    <= '0;
      run_en_reg    <= 1'b1;
      load_reg      <= 1'b0;
      load_val_reg  <= '0;
      disp_reg      <= '0;
      blank_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      sh_reg        <= sh_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      to_cnt_reg    <= to_cnt_next;
      run_en_reg    <= run_en_next;
      load_reg      <= load_next;
      load_val_reg  <= load_val_next;
      disp_reg      <= disp_next;
      blank_reg     <= blank_next;
    end
  end

  assign mode        = state_reg;
  assign run_en      = run_en_reg;
  assign load        = load_reg;
  assign digit_blank = blank_reg;
  assign {load_hrs_1, load_hrs_0, load_min_1, load_min_0} = load_val_reg;
  assign {disp_hrs_1, disp_hrs_0, disp_min_1, disp_min_0} = disp_reg;

endmodule
